// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the core's single unified memory port.
// Port 0 has fixed priority; a starvation counter eventually forces a port 1 grant.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int MAX_STARVE  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int STARVE_W = (MAX_STARVE < 2) ? 1 : $clog2(MAX_STARVE + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(WAIT_CYCLES);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                owner_q, owner_d;
  logic                grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    owner_d     = owner_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    req0_rvalid = 1'b0;
    req1_rvalid = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    // Port 1 wins alone, or when it has lost MAX_STARVE contested rounds in a row.
    grant1      = req1_valid && (!req0_valid || (starve_q == STARVE_MAX));

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = !grant1;
          req1_ready = grant1;
          owner_d    = grant1;
          addr_d     = grant1 ? req1_addr  : req0_addr;
          wdata_d    = grant1 ? req1_wdata : req0_wdata;
          we_d       = grant1 ? req1_we    : req0_we;
          cnt_d      = '0;
          state_d    = ACCESS;
          if (grant1) begin
            starve_d = '0;
          end else if (req1_valid && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          mem_we  = we_q;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end
      end
      DONE: begin
        req0_rvalid = !owner_q;
        req1_rvalid = owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata = rdata_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: WAIT_CYCLES=2 instance for the main
// scenarios, plus a WAIT_CYCLES=0 instance for the single-cycle access case.
module tb_mem_port_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          total = 0;
  int          bad = 0;
  logic [31:0] lastRdata = '0;

  // instance A (WAIT_CYCLES = 2)
  logic        req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
  logic [31:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
  logic        req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic        mem_en, mem_we, busy;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  // instance B (WAIT_CYCLES = 0)
  logic        b_req0_valid = 0, b_req0_we = 0, b_req1_valid = 0, b_req1_we = 0;
  logic [31:0] b_req0_addr = '0, b_req0_wdata = '0, b_req1_addr = '0, b_req1_wdata = '0;
  logic        b_req0_ready, b_req0_rvalid, b_req1_ready, b_req1_rvalid;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  always #5 clk = ~clk;

  function automatic logic [31:0] memModel(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rdata   = memModel(mem_addr);
  assign b_mem_rdata = memModel(b_mem_addr);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W), .MAX_STARVE(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0), .MAX_STARVE(4)) dutB (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_we(b_req0_we), .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata),
    .req0_ready(b_req0_ready), .req0_rvalid(b_req0_rvalid),
    .req1_valid(b_req1_valid), .req1_we(b_req1_we), .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
    .req1_ready(b_req1_ready), .req1_rvalid(b_req1_rvalid),
    .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drives one request into instance A at cycle 0 and checks every cycle up to the rvalid cycle.
  task automatic applyStimulus(input logic v0, input logic v1, input int port, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic hold);
    for (int c = 0; c <= W + 2; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req0_valid = v0;
        req1_valid = v1;
      end
      #1;
      checkOutput("ready0", 32'(req0_ready), 32'(c == 0 && port == 0));
      checkOutput("ready1", 32'(req1_ready), 32'(c == 0 && port == 1));
      checkOutput("mem_en", 32'(mem_en), 32'(c >= 1 && c <= W + 1));
      checkOutput("mem_we", 32'(mem_we), 32'(c == W + 1 && we));
      checkOutput("busy", 32'(busy), 32'(c != 0));
      checkOutput("rvalid0", 32'(req0_rvalid), 32'(c == W + 2 && port == 0));
      checkOutput("rvalid1", 32'(req1_rvalid), 32'(c == W + 2 && port == 1));
      if (c >= 1 && c <= W + 1) begin
        checkOutput("mem_addr", mem_addr, addr);
        if (we) checkOutput("mem_wdata", mem_wdata, wdata);
      end
      if (c == W + 2) begin
        if (!we) lastRdata = memModel(addr);
        checkOutput("rdata", rdata, lastRdata);
        if (!hold) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    @(negedge clk); #1;
    checkOutput("rst_ready0", 32'(req0_ready), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rvalid0", 32'(req0_rvalid), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_b_busy", 32'(b_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single read from port 0
    req0_addr = 32'h40; req0_we = 1'b0;
    applyStimulus(1, 0, 0, 0, 32'h40, 32'h0, 0);

    // write from port 1; rdata must keep the previous read value
    req1_addr = 32'h80; req1_we = 1'b1; req1_wdata = 32'h12345678;
    applyStimulus(0, 1, 1, 1, 32'h80, 32'h12345678, 0);

    // back-to-back port 0 reads with valid held high
    req0_addr = 32'h44;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 32'h44, 32'h0, i != 2);

    // contention: port 1 must win every fifth round
    req0_addr = 32'h100; req0_we = 1'b0;
    req1_addr = 32'h200; req1_we = 1'b1; req1_wdata = 32'h55AA;
    for (int g = 0; g < 10; g++) begin
      if (g % 5 == 4) applyStimulus(1, 1, 1, 1, 32'h200, 32'h55AA, g != 9);
      else            applyStimulus(1, 1, 0, 0, 32'h100, 32'h0, g != 9);
    end

    // reset in the middle of a port 0 write
    req0_addr = 32'h300; req0_we = 1'b1; req0_wdata = 32'hCAFEF00D;
    @(negedge clk); req0_valid = 1'b1; #1;
    checkOutput("rw_ready0", 32'(req0_ready), 32'd1);
    @(negedge clk); req0_valid = 1'b0; #1;
    checkOutput("rw_mem_en1", 32'(mem_en), 32'd1);
    checkOutput("rw_mem_we1", 32'(mem_we), 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        @(negedge clk); rst = 1'b0; #1;
      end else if (i > 0) begin
        @(negedge clk); #1;
      end
      checkOutput("rw_busy", 32'(busy), 32'd0);
      checkOutput("rw_mem_en", 32'(mem_en), 32'd0);
      checkOutput("rw_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rw_rvalid0", 32'(req0_rvalid), 32'd0);
      checkOutput("rw_mem_addr", mem_addr, 32'd0);
    end
    lastRdata = 32'h0;
    checkOutput("rw_rdata_clr", rdata, 32'd0);
    req0_we = 1'b0; req0_addr = 32'h40;
    applyStimulus(1, 0, 0, 0, 32'h40, 32'h0, 0);

    // WAIT_CYCLES = 0: read on port 0, then write on port 1
    @(negedge clk); b_req0_valid = 1'b1; b_req0_addr = 32'h44; #1;
    checkOutput("b_ready0", 32'(b_req0_ready), 32'd1);
    @(negedge clk); b_req0_valid = 1'b0; #1;
    checkOutput("b_mem_en1", 32'(b_mem_en), 32'd1);
    checkOutput("b_mem_we1", 32'(b_mem_we), 32'd0);
    checkOutput("b_mem_addr", b_mem_addr, 32'h44);
    @(negedge clk); #1;
    checkOutput("b_mem_en2", 32'(b_mem_en), 32'd0);
    checkOutput("b_rvalid0", 32'(b_req0_rvalid), 32'd1);
    checkOutput("b_rdata", b_rdata, memModel(32'h44));
    @(negedge clk); b_req1_valid = 1'b1; b_req1_we = 1'b1;
    b_req1_addr = 32'h88; b_req1_wdata = 32'hA1B2C3D4; #1;
    checkOutput("b_busy3", 32'(b_busy), 32'd0);
    checkOutput("b_rvalid0_off", 32'(b_req0_rvalid), 32'd0);
    checkOutput("b_ready1", 32'(b_req1_ready), 32'd1);
    @(negedge clk); b_req1_valid = 1'b0; #1;
    checkOutput("b_mem_we_w", 32'(b_mem_we), 32'd1);
    checkOutput("b_mem_wdata", b_mem_wdata, 32'hA1B2C3D4);
    @(negedge clk); #1;
    checkOutput("b_rvalid1", 32'(b_req1_rvalid), 32'd1);
    checkOutput("b_rdata_hold", b_rdata, memModel(32'h44));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
